niu_sii_req_arb: RTL

- Shares the single NIU→SII inbound request port among `NREQ` NIU DMA requesters.
- Arbitration is round-robin and gated by per-queue credits; one request is granted at a time.
- Sequences the granted request onto the port:
  - Reads: one header cycle.
  - Writes: one header cycle, then four 128-bit payload cycles.
- Sits between the NIU DMA engines and SII; owns credit accounting for the SII ordered and bypass queues.

---
 rtl/niu_sii_req_arb.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/niu_sii_req_arb.sv
// NIU->SII inbound request arbiter: round-robin, credit-gated sharing of the SII request port.
// Optional per-lane data parity is generated when NIU_SII_ARB_PARITY_EN is defined.
module niu_sii_req_arb #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned OQ_CREDITS = 16,
  parameter int unsigned BQ_CREDITS = 16
) (
  input  logic                iol2clk,
  input  logic                rst_l,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [NREQ-1:0]     req_bypass,
  input  logic [NREQ*128-1:0] req_hdr,
  input  logic [NREQ*16-1:0]  req_be,
  input  logic [NREQ*128-1:0] req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     data_beat,
  input  logic                sii_niu_oqdq,
  input  logic                sii_niu_bqdq,
  output logic                niu_sii_hdr_vld,
  output logic                niu_sii_reqbypass,
  output logic                niu_sii_datareq,
  output logic                niu_sii_datareq16,
  output logic [127:0]        niu_sii_data,
  output logic [7:0]          niu_sii_parity,
  output logic [15:0]         niu_sii_be,
  output logic                credit_err
);

  localparam int unsigned DW   = 128;
  localparam int unsigned BEW  = 16;
  localparam int unsigned PARW = 8;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned OQW  = $clog2(OQ_CREDITS + 1);
  localparam int unsigned BQW  = $clog2(BQ_CREDITS + 1);
  localparam logic [OQW-1:0] OQ_MAX = OQW'(OQ_CREDITS);
  localparam logic [BQW-1:0] BQ_MAX = BQW'(BQ_CREDITS);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} state_e;

  state_e          state_q, state_d;
  logic [1:0]      bc_q, bc_d;
  logic [PW-1:0]   cur_q, cur_d;
  logic            cur_wr_q, cur_wr_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [OQW-1:0]  oq_cred_q, oq_cred_d;
  logic [BQW-1:0]  bq_cred_q, bq_cred_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] beat_q, beat_d;
  logic            hdr_vld_q, hdr_vld_d;
  logic            byp_q, byp_d;
  logic            dreq_q, dreq_d;
  logic [DW-1:0]   data_q, data_d;
  logic [BEW-1:0]  be_q, be_d;

  logic [DW-1:0]   hdr_a [NREQ];
  logic [DW-1:0]   dat_a [NREQ];
  logic [BEW-1:0]  be_a  [NREQ];
  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   scan_idx;
  logic            arb_slot;
  logic            issue_oq, issue_bq;
  logic            oq_ovf, bq_ovf;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign hdr_a[g] = req_hdr[g*DW +: DW];
    assign dat_a[g] = req_data[g*DW +: DW];
    assign be_a[g]  = req_be[g*BEW +: BEW];
  end

  // A requester is eligible only if its target queue still has a credit.
  assign elig = req_vld & ((req_bypass & {NREQ{bq_cred_q != '0}}) |
                           (~req_bypass & {NREQ{oq_cred_q != '0}}));

  // Round-robin search starting at rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'((32'(rr_q) + k) % NREQ);
      if (!win_found && elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    cur_d     = cur_q;
    cur_wr_d  = cur_wr_q;
    rr_d      = rr_q;
    gnt_d     = '0;
    beat_d    = '0;
    hdr_vld_d = 1'b0;
    byp_d     = 1'b0;
    dreq_d    = 1'b0;
    data_d    = '0;
    be_d      = '0;
    issue_oq  = 1'b0;
    issue_bq  = 1'b0;
    arb_slot  = 1'b0;
    case (state_q)
      ST_IDLE: arb_slot = 1'b1;
      ST_HDR: begin
        if (cur_wr_q) begin
          state_d        = ST_PAY;
          bc_d           = 2'd0;
          data_d         = dat_a[cur_q];
          beat_d[cur_q]  = 1'b1;
        end else begin
          arb_slot = 1'b1;
        end
      end
      ST_PAY: begin
        if (bc_q == 2'd3) begin
          arb_slot = 1'b1;
        end else begin
          bc_d          = bc_q + 2'd1;
          data_d        = dat_a[cur_q];
          beat_d[cur_q] = (bc_q != 2'd2);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (arb_slot) begin
      if (win_found) begin
        state_d          = ST_HDR;
        cur_d            = win_idx;
        cur_wr_d         = req_wr[win_idx];
        rr_d             = PW'((32'(win_idx) + 32'd1) % NREQ);
        gnt_d[win_idx]   = 1'b1;
        beat_d[win_idx]  = req_wr[win_idx];
        hdr_vld_d        = 1'b1;
        byp_d            = req_bypass[win_idx];
        dreq_d           = req_wr[win_idx];
        data_d           = hdr_a[win_idx];
        be_d             = req_wr[win_idx] ? be_a[win_idx] : '0;
        issue_bq         = req_bypass[win_idx];
        issue_oq         = !req_bypass[win_idx];
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Credit accounting; a simultaneous issue and return cancel out.
  always_comb begin
    oq_cred_d = oq_cred_q;
    bq_cred_d = bq_cred_q;
    oq_ovf    = 1'b0;
    bq_ovf    = 1'b0;
    case ({issue_oq, sii_niu_oqdq})
      2'b10:   oq_cred_d = oq_cred_q - OQW'(1);
      2'b01: begin
        if (oq_cred_q == OQ_MAX) oq_ovf = 1'b1;
        else                     oq_cred_d = oq_cred_q + OQW'(1);
      end
      default: oq_cred_d = oq_cred_q;
    endcase
    case ({issue_bq, sii_niu_bqdq})
      2'b10:   bq_cred_d = bq_cred_q - BQW'(1);
      2'b01: begin
        if (bq_cred_q == BQ_MAX) bq_ovf = 1'b1;
        else                     bq_cred_d = bq_cred_q + BQW'(1);
      end
      default: bq_cred_d = bq_cred_q;
    endcase
    err_d = err_q | oq_ovf | bq_ovf;
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      state_q   <= ST_IDLE;
      bc_q      <= '0;
      cur_q     <= '0;
      cur_wr_q  <= 1'b0;
      rr_q      <= '0;
      oq_cred_q <= OQ_MAX;
      bq_cred_q <= BQ_MAX;
      err_q     <= 1'b0;
      gnt_q     <= '0;
      beat_q    <= '0;
      hdr_vld_q <= 1'b0;
      byp_q     <= 1'b0;
      dreq_q    <= 1'b0;
      data_q    <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      cur_q     <= cur_d;
      cur_wr_q  <= cur_wr_d;
      rr_q      <= rr_d;
      oq_cred_q <= oq_cred_d;
      bq_cred_q <= bq_cred_d;
      err_q     <= err_d;
      gnt_q     <= gnt_d;
      beat_q    <= beat_d;
      hdr_vld_q <= hdr_vld_d;
      byp_q     <= byp_d;
      dreq_q    <= dreq_d;
      data_q    <= data_d;
      be_q      <= be_d;
    end
  end

`ifdef NIU_SII_ARB_PARITY_EN
  logic [PARW-1:0] par_d, par_q;

  for (genvar p = 0; p < PARW; p++) begin : g_par
    assign par_d[p] = ^data_d[p*16 +: 16];
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) par_q <= '0;
    else        par_q <= par_d;
  end

  assign niu_sii_parity = par_q;
`else
  assign niu_sii_parity = '0;
`endif

  assign gnt               = gnt_q;
  assign data_beat         = beat_q;
  assign niu_sii_hdr_vld   = hdr_vld_q;
  assign niu_sii_reqbypass = byp_q;
  assign niu_sii_datareq   = dreq_q;
  assign niu_sii_datareq16 = 1'b0;
  assign niu_sii_data      = data_q;
  assign niu_sii_be        = be_q;
  assign credit_err        = err_q;

endmodule
